ula_multiciclo: RTL and testbench
=================================

ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), width of shift-amount fields.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is asynchronous and active-low.
REQ-005 start  input  1  request; operands and opcode sampled on a clk edge where start=1 and busy=0.
REQ-006 alu_control  input  5  opcode (table in REQ-012..014).
REQ-007 a, b  input  WIDTH  operands.
REQ-008 shamt  input  SHW  immediate shift amount.
REQ-009 result  output  WIDTH  registered result, held until the next completion.
REQ-010 zero, done, busy, div_by_zero  output  1 each  result==0; one-cycle completion pulse; operation in flight; last completed DIV/DIVU had b==0.
REQ-011 hi, lo  output  WIDTH  HI/LO registers.

Function
REQ-012 Codes 0_xxxx (single-cycle): 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 0100 NOR, 0111 SLT signed, 1000 SLTU, 1001 SLL b<<shamt, 1010 SRL b>>shamt, 1011 LUI b<<(WIDTH/2), 1100 SLLV, 1101 SRLV, 1110 SRAV, 1111 SRA b>>>shamt; ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-013 Variable shifts use a[SHW-1:0] only; upper bits of a ignored.
REQ-014 Codes 1_xxxx: 10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU, 10100 MFHI (result=hi), 10101 MFLO (result=lo), 10110 MTHI (hi=a), 10111 MTLO (lo=a); 11000..11111 single-cycle, result=0.
REQ-015 State machine: IDLE, MUL, DIV, FIN; reset state IDLE.
REQ-016 IDLE + accepted start of single-cycle op: result (and hi/lo for MTHI/MTLO) written on that edge, done=1 next cycle, state stays IDLE, busy stays 0; latency 1.
REQ-017 IDLE + accepted MULT/MULTU: go MUL, busy=1; iterative shift-add, one bit per cycle, WIDTH cycles, then FIN.
REQ-018 IDLE + accepted DIV/DIVU with b!=0: go DIV, busy=1; restoring division, one quotient bit per cycle, WIDTH cycles, then FIN.
REQ-019 FIN: write {hi,lo}, result=lo, busy=0, done=1 for that one cycle, return to IDLE; total latency start-edge to done = WIDTH+1 cycles.
REQ-020 MULT signed: 2*WIDTH-bit two's-complement product, hi=upper half, lo=lower half; MULTU unsigned.
REQ-021 DIV signed: lo=quotient truncated toward zero, hi=remainder with sign of a; DIVU unsigned; most-negative / -1 gives lo=most-negative, hi=0.
REQ-022 DIV/DIVU with b==0: treated single-cycle (REQ-016); lo=all ones, hi=a, result=lo, div_by_zero=1; any other completed DIV/DIVU clears div_by_zero.
REQ-023 start while busy=1 ignored; no queuing; operands may change freely while busy.
REQ-024 hi/lo change only on MUL/DIV completion, div-by-zero, MTHI, MTLO.
REQ-025 zero combinational from registered result.
REQ-026 done never asserted two consecutive cycles from one request; back-to-back single-cycle starts give one done per accepted start.

Reset
REQ-027 rst_n=0 asynchronously forces: state IDLE, result=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0, zero=1.
REQ-028 Reset mid-MUL/DIV aborts the operation; no done, hi/lo=0; first start after rst_n rises is accepted normally.

Verification
REQ-029 WIDTH=32: ADD a=0xFFFFFFFF b=1 -> next cycle result=0, zero=1, done=1, busy=0.
REQ-030 WIDTH=32: MULT a=-3 b=7 -> busy 32 cycles, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU same operands -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-031 WIDTH=32: DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> 1-cycle, lo=0xFFFFFFFF, hi=7, div_by_zero=1.
REQ-032 WIDTH=32: start ADD pulsed during MULT busy -> ignored, hi/lo = product only, single done.
REQ-033 WIDTH=16: SRAV a=0x0013 b=0x8000 -> uses shift 3 -> result=0xF000; LUI b=0x00AB -> 0xAB00.
REQ-034 rst_n low at cycle 10 of DIV -> busy=0, hi=lo=0 immediately; no done; subsequent MFLO -> result=0.

Source files
------------

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/shift/compare ops plus iterative
// shift-add multiply and restoring divide writing a HI/LO register pair.
module ula_multiciclo #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t               state, state_nx;
  logic [2*WIDTH-1:0]   acc, opb;
  logic [WIDTH-1:0]     opa;
  logic [SHW-1:0]       cnt;
  logic                 neg_q, neg_r;

  logic                 accept, is_mul, is_div, b_zero, sgn, last;
  logic [WIDTH-1:0]     abs_a, abs_b, alu_res;
  logic [2*WIDTH-1:0]   prod_nx, prod_fin;
  logic [WIDTH:0]       shifted, trial;
  logic [WIDTH-1:0]     rem_nx, quo_nx, rem_fin, quo_fin;

  assign busy   = (state == MUL) || (state == DIV);
  assign accept = start && !busy;
  assign is_mul = (alu_control[4:1] == 4'b1000);
  assign is_div = (alu_control[4:1] == 4'b1001);
  assign b_zero = (b == '0);
  assign sgn    = ~alu_control[0];
  assign last   = (cnt == '0);
  assign zero   = (result == '0);

  // Signed MUL/DIV run on magnitudes; signs are reapplied at completion.
  assign abs_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (sgn && b[WIDTH-1]) ? -b : b;

  always_comb begin
    prod_nx  = acc + (opa[0] ? opb : '0);
    prod_fin = neg_q ? -prod_nx : prod_nx;
    shifted  = {acc[WIDTH-1:0], opa[WIDTH-1]};
    trial    = shifted - {1'b0, opb[WIDTH-1:0]};
    rem_nx   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx   = {opa[WIDTH-2:0], ~trial[WIDTH]};
    quo_fin  = neg_q ? -quo_nx : quo_nx;
    rem_fin  = neg_r ? -rem_nx : rem_nx;
  end

  always_comb begin
    alu_res = '0;
    case (alu_control)
      5'b00010: alu_res = a + b;
      5'b00110: alu_res = a - b;
      5'b00000: alu_res = a & b;
      5'b00001: alu_res = a | b;
      5'b00011: alu_res = a ^ b;
      5'b00100: alu_res = ~(a | b);
      5'b00111: alu_res = WIDTH'($signed(a) < $signed(b));
      5'b01000: alu_res = WIDTH'(a < b);
      5'b01001: alu_res = b << shamt;
      5'b01010: alu_res = b >> shamt;
      5'b01011: alu_res = b << (WIDTH/2);
      5'b01100: alu_res = b << a[SHW-1:0];
      5'b01101: alu_res = b >> a[SHW-1:0];
      5'b01110: alu_res = $signed(b) >>> a[SHW-1:0];
      5'b01111: alu_res = $signed(b) >>> shamt;
      5'b10100: alu_res = hi;
      5'b10101: alu_res = lo;
      5'b10110,
      5'b10111: alu_res = a;
      5'b10010,
      5'b10011: alu_res = '1;   // divide by zero reaches here only with b==0
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FIN: begin
        state_nx = IDLE;
        if (accept && is_mul)                state_nx = MUL;
        else if (accept && is_div && !b_zero) state_nx = DIV;
      end
      MUL, DIV: if (last) state_nx = FIN;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      opa         <= '0;
      opb         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MUL: begin
          acc <= prod_nx;
          opa <= opa >> 1;
          opb <= opb << 1;
          cnt <= cnt - 1'b1;
          if (last) begin
            {hi, lo} <= prod_fin;
            result   <= prod_fin[WIDTH-1:0];
            done     <= 1'b1;
          end
        end
        DIV: begin
          acc <= {{WIDTH{1'b0}}, rem_nx};
          opa <= quo_nx;
          cnt <= cnt - 1'b1;
          if (last) begin
            hi          <= rem_fin;
            lo          <= quo_fin;
            result      <= quo_fin;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: if (accept) begin
          if (is_mul || (is_div && !b_zero)) begin
            acc   <= '0;
            opa   <= abs_a;
            opb   <= {{WIDTH{1'b0}}, abs_b};
            cnt   <= SHW'(WIDTH-1);
            neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn & a[WIDTH-1];
          end else begin
            result <= alu_res;
            done   <= 1'b1;
            if (alu_control == 5'b10110) hi <= a;
            if (alu_control == 5'b10111) lo <= a;
            if (is_div) begin
              hi          <= a;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomized + directed bench for ula_multiciclo against an arithmetic
// reference model (32-bit instance) plus a few 16-bit directed checks.
module tb_ula_multiciclo;

  localparam logic [4:0] ADD = 5'b00010, SUB = 5'b00110, XOR_ = 5'b00011;
  localparam logic [4:0] MULT = 5'b10000, MULTU = 5'b10001, DIV = 5'b10010, DIVU = 5'b10011;
  localparam logic [4:0] MFHI = 5'b10100, MFLO = 5'b10101, MTHI = 5'b10110, MTLO = 5'b10111;
  localparam logic [4:0] SRAV = 5'b01110, LUI = 5'b01011;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  alu_control = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result, hi, lo;
  logic        zero, done, busy, div_by_zero;

  logic        start16 = 1'b0;
  logic [4:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  sh16 = '0;
  logic [15:0] result16, hi16, lo16;
  logic        zero16, done16, busy16, dbz16;

  int nvec = 0, nmis = 0;

  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0;
  logic        m_dbz = 1'b0;
  bit          res_known = 1'b1;

  ula_multiciclo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
    .a(a), .b(b), .shamt(shamt), .result(result), .zero(zero), .done(done),
    .busy(busy), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  ula_multiciclo #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .alu_control(op16),
    .a(a16), .b(b16), .shamt(sh16), .result(result16), .zero(zero16), .done(done16),
    .busy(busy16), .div_by_zero(dbz16), .hi(hi16), .lo(lo16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the op definitions.
  task automatic model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh);
    longint sx, sy, q, r;
    logic [63:0] p;
    res_known = 1'b1;
    sx = $signed(x);
    sy = $signed(y);
    case (op)
      5'b00010: m_res = x + y;
      5'b00110: m_res = x - y;
      5'b00000: m_res = x & y;
      5'b00001: m_res = x | y;
      5'b00011: m_res = x ^ y;
      5'b00100: m_res = ~(x | y);
      5'b00111: m_res = {31'b0, sx < sy};
      5'b01000: m_res = {31'b0, x < y};
      5'b01001: m_res = y << sh;
      5'b01010: m_res = y >> sh;
      5'b01011: m_res = y << 16;
      5'b01100: m_res = y << x[4:0];
      5'b01101: m_res = y >> x[4:0];
      5'b01110: m_res = 32'(sy >>> x[4:0]);
      5'b01111: m_res = 32'(sy >>> sh);
      5'b10000: begin p = sx * sy; {m_hi, m_lo} = p; m_res = m_lo; end
      5'b10001: begin p = {32'b0, x} * {32'b0, y}; {m_hi, m_lo} = p; m_res = m_lo; end
      5'b10010, 5'b10011: begin
        if (y == 0) begin
          m_lo = '1; m_hi = x; m_dbz = 1'b1;
        end else if (op == DIV) begin
          q = sx / sy; r = sx % sy;
          m_lo = q[31:0]; m_hi = r[31:0]; m_dbz = 1'b0;
        end else begin
          m_lo = x / y; m_hi = x % y; m_dbz = 1'b0;
        end
        m_res = m_lo;
      end
      5'b10100: m_res = m_hi;
      5'b10101: m_res = m_lo;
      5'b10110: begin m_hi = x; res_known = 1'b0; end
      5'b10111: begin m_lo = x; res_known = 1'b0; end
      default:  m_res = '0;
    endcase
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] sh, input bit intr);
    int lat, bcnt;
    bit multi;
    multi = (op == MULT) || (op == MULTU) || ((op == DIV || op == DIVU) && y != 0);
    model(op, x, y, sh);
    @(negedge clk);
    start = 1'b1; alu_control = op; a = x; b = y; shamt = sh;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      start = (intr && lat == 5);
      alu_control = intr ? ADD : op;
      a = $urandom; b = $urandom;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", 64'(lat), multi ? 64'd33 : 64'd1);
    chk("busy_cycles", 64'(bcnt), multi ? 64'd32 : 64'd0);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    if (res_known) begin
      chk("result", 64'(result), 64'(m_res));
      chk("zero", 64'(zero), 64'(m_res == 0));
    end
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic run16(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    start16 = 1'b1; op16 = op; a16 = x; b16 = y; sh16 = '0;
    @(negedge clk);
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("w16_latency", 64'(lat), 64'(exp_lat));
    chk("w16_result", 64'(result16), 64'(exp_res));
    chk("w16_busy", 64'(busy16), 64'd0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] ops [23] = '{5'b00010, 5'b00110, 5'b00000, 5'b00001, 5'b00011, 5'b00100,
                           5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
                           5'b01101, 5'b01110, 5'b01111, MULT, MULTU, DIV, DIVU,
                           MFHI, MFLO, MTHI, MTLO};
  logic [4:0] bb_ops [3] = '{ADD, SUB, XOR_};

  initial begin
    logic [31:0] expq;
    int ndone;

    repeat (2) @(negedge clk);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", 64'({busy, done, div_by_zero, zero}), 64'b0001);
    rst_n = 1'b1;

    run_op(ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
    run_op(MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b0);
    run_op(MULTU, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b0);
    run_op(MULT, 32'd5, 32'd6, 5'd0, 1'b1);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0);
    run_op(DIVU, 32'd7, 32'd0, 5'd0, 1'b0);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
    run_op(MTHI, 32'h1234_5678, 32'd0, 5'd0, 1'b0);
    run_op(MFHI, 32'd0, 32'd0, 5'd0, 1'b0);
    run_op(MTLO, 32'h0BAD_F00D, 32'd0, 5'd0, 1'b0);
    run_op(MFLO, 32'd0, 32'd0, 5'd0, 1'b0);

    // Back-to-back single-cycle starts: one done and result per accepted start.
    expq = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_done", 64'(done), 64'd1);
        chk("b2b_result", 64'(result), 64'(expq));
      end
      start = 1'b1; alu_control = bb_ops[i]; a = $urandom; b = $urandom; shamt = '0;
      model(bb_ops[i], a, b, shamt);
      expq = m_res;
    end
    @(negedge clk);
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_result", 64'(result), 64'(expq));
    start = 1'b0;
    @(negedge clk);
    chk("b2b_done_end", 64'(done), 64'd0);

    for (int n = 0; n < 40; n++)
      run_op(ops[$urandom_range(0, 22)], rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)), 1'b0);

    run16(SRAV, 16'h0013, 16'h8000, 16'hF000, 1);
    run16(LUI, 16'h0000, 16'h00AB, 16'hAB00, 1);
    run16(MULT, 16'hFFFD, 16'h0007, 16'hFFEB, 17);
    chk("w16_hi", 64'(hi16), 64'hFFFF);
    chk("w16_lo", 64'(lo16), 64'hFFEB);
    chk("w16_flags", 64'({zero16, dbz16}), 64'd0);

    // Abort a DIV mid-flight with reset.
    run_op(MULT, 32'h0001_2345, 32'h0000_0777, 5'd0, 1'b0);
    @(negedge clk);
    start = 1'b1; alu_control = DIV; a = 32'hFFFF_FF9C; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    m_hi = '0; m_lo = '0; m_res = '0; m_dbz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_op(MFLO, 32'd0, 32'd0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
